// File: rtl/friscv_mem_arbiter.sv
// friscv_mem_arbiter: round-robin arbiter giving two requesters a shared, registered data-memory port with a no-ack watchdog
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              srst,
  input  logic              req0_en,
  input  logic              req0_wr,
  input  logic [ADDRW-1:0]  req0_addr,
  input  logic [XLEN-1:0]   req0_wdata,
  input  logic [XLEN/8-1:0] req0_strb,
  output logic [XLEN-1:0]   req0_rdata,
  output logic              req0_ready,
  output logic              req0_err,
  input  logic              req1_en,
  input  logic              req1_wr,
  input  logic [ADDRW-1:0]  req1_addr,
  input  logic [XLEN-1:0]   req1_wdata,
  input  logic [XLEN/8-1:0] req1_strb,
  output logic [XLEN-1:0]   req1_rdata,
  output logic              req1_ready,
  output logic              req1_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDRW-1:0]  mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;
  logic last, gnt, pick, done;
  logic [WW-1:0] wdog;
  logic [XLEN-1:0] rsp;
  always_comb begin
    pick = (req0_en && req1_en) ? !last : req1_en;
    done = mem_ready || wdog == WD_MAX;
    rsp  = mem_ready ? mem_rdata : '0;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      last <= 1'b1;
      gnt <= 1'b0;
      wdog <= '0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_strb <= '0;
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_err <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_err <= 1'b0;
    end else if (srst) begin
      state <= IDLE;
      last <= 1'b1;
      gnt <= 1'b0;
      wdog <= '0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_strb <= '0;
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_err <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_en || req1_en) begin
          gnt <= pick;
          last <= pick;
          wdog <= '0;
          mem_en <= 1'b1;
          mem_wr <= pick ? req1_wr : req0_wr;
          mem_addr <= pick ? req1_addr : req0_addr;
          mem_wdata <= pick ? req1_wdata : req0_wdata;
          mem_strb <= pick ? req1_strb : req0_strb;
          state <= REQ;
        end
        // a mem_ready arriving on the watchdog's last cycle still wins over the timeout
        REQ: if (done) begin
          mem_en <= 1'b0;
          req0_ready <= !gnt;
          req1_ready <= gnt;
          req0_rdata <= gnt ? '0 : rsp;
          req1_rdata <= gnt ? rsp : '0;
          req0_err <= !gnt && !mem_ready;
          req1_err <= gnt && !mem_ready;
          state <= RESP;
        end else begin
          wdog <= wdog + WW'(1);
        end
        RESP: begin
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          req0_rdata <= '0;
          req1_rdata <= '0;
          req0_err <= 1'b0;
          req1_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// tb_friscv_mem_arbiter: scoreboard bench with directed requests, a behavioural memory and bus/response monitors
module tb_friscv_mem_arbiter;
  logic aclk = 1'b0, areset = 1'b1, srst = 1'b0;
  logic req0_en = 0, req0_wr = 0, req1_en = 0, req1_wr = 0;
  logic [15:0] req0_addr = '0, req1_addr = '0, mem_addr;
  logic [31:0] req0_wdata = '0, req1_wdata = '0, req0_rdata, req1_rdata, mem_wdata;
  logic [3:0] req0_strb = '0, req1_strb = '0, mem_strb;
  logic req0_ready, req0_err, req1_ready, req1_err, mem_en, mem_wr;
  logic [31:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  int n_cmp = 0, n_fail = 0, n_rdy = 0, mem_delay = 0;
  bit mem_dead = 0;
  typedef struct packed {logic wr; logic [15:0] addr; logic [31:0] wdata; logic [3:0] strb; int len;} mexp_t;
  typedef struct packed {logic id; logic [31:0] rdata; logic err;} rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];

  friscv_mem_arbiter #(.ADDRW(16), .XLEN(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset), .srst(srst),
    .req0_en(req0_en), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_strb(req0_strb), .req0_rdata(req0_rdata), .req0_ready(req0_ready), .req0_err(req0_err),
    .req1_en(req1_en), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_strb(req1_strb), .req1_rdata(req1_rdata), .req1_ready(req1_ready), .req1_err(req1_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_m(input logic wr, input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] strb, input int len);
    mq.push_back('{wr: wr, addr: addr, wdata: wdata, strb: strb, len: len});
  endtask

  task automatic push_r(input logic id, input logic [31:0] rdata, input logic err);
    rq.push_back('{id: id, rdata: rdata, err: err});
  endtask

  // raise a request, wait for its ready, drop en on the following cycle
  task automatic do_req(input logic id, input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int exp_lat);
    int n = 0;
    bit seen = 0;
    if (id) begin
      req1_wr = wr; req1_addr = addr; req1_wdata = wdata; req1_strb = strb; req1_en = 1;
    end else begin
      req0_wr = wr; req0_addr = addr; req0_wdata = wdata; req0_strb = strb; req0_en = 1;
    end
    while (!seen && n < 60) begin
      @(posedge aclk); #1;
      n++;
      seen = id ? req1_ready : req0_ready;
    end
    if (!seen) chk("ready_wait", 64'(0), 64'(1));
    else if (exp_lat >= 0) chk("latency", 64'(n), 64'(exp_lat));
    @(posedge aclk); #1;
    if (id) req1_en = 0; else req0_en = 0;
  endtask

  // memory: answers after mem_delay wait cycles with address-derived data
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge aclk); #1;
      if (mem_ready) mem_ready = 0;
      else if (mem_en && !mem_dead) begin
        if (wait_cnt == mem_delay) begin
          mem_rdata = (mem_addr == 16'h0010) ? 32'hDEADBEEF : {~mem_addr, mem_addr};
          mem_ready = 1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else if (!mem_en) wait_cnt = 0;
    end
  end

  // memory bus monitor: request fields, stability and mem_en length
  initial begin
    bit prev_en = 0;
    int len = 0;
    mexp_t e = '0;
    logic [52:0] cap = '0;
    forever begin
      @(negedge aclk);
      if (mem_en && !prev_en) begin
        len = 1;
        cap = {mem_wr, mem_addr, mem_wdata, mem_strb};
        if (mq.size() == 0) chk("unexpected_mem_req", 64'(cap), 64'(0));
        else begin
          e = mq.pop_front();
          chk("mem_req", 64'(cap), 64'({e.wr, e.addr, e.wdata, e.strb}));
        end
      end else if (mem_en && prev_en) begin
        len++;
        chk("mem_stable", 64'({mem_wr, mem_addr, mem_wdata, mem_strb}), 64'(cap));
      end else if (!mem_en && prev_en) chk("mem_en_len", 64'(len), 64'(e.len));
      prev_en = mem_en;
    end
  end

  // response monitor: granted side carries data, other side stays zero
  initial begin
    bit prev_rdy = 0;
    rexp_t r;
    forever begin
      @(negedge aclk);
      if (req0_ready || req1_ready) begin
        n_rdy++;
        chk("ready_pulse", 64'(prev_rdy), 64'(0));
        if (rq.size() == 0) chk("unexpected_ready", 64'({req1_ready, req0_ready}), 64'(0));
        else begin
          r = rq.pop_front();
          chk("rsp_id", 64'({req1_ready, req0_ready}), 64'(r.id ? 2 : 1));
          chk("rsp_rdata", 64'(r.id ? req1_rdata : req0_rdata), 64'(r.rdata));
          chk("rsp_err", 64'(r.id ? req1_err : req0_err), 64'(r.err));
          chk("other_zero", 64'(r.id ? {req0_err, req0_rdata} : {req1_err, req1_rdata}), 64'(0));
        end
      end
      prev_rdy = req0_ready || req1_ready;
    end
  end

  initial begin
    repeat (20000) @(posedge aclk);
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int rdy0;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(negedge aclk);
    chk("rst_mem", 64'({mem_en, mem_wr, mem_addr, mem_wdata, mem_strb}), 64'(0));
    chk("rst_rsp0", 64'({req0_ready, req0_err, req0_rdata}), 64'(0));
    chk("rst_rsp1", 64'({req1_ready, req1_err, req1_rdata}), 64'(0));
    @(posedge aclk); #1;
    // tie after reset goes to 0, then strict alternation
    for (int i = 0; i < 2; i++) begin
      push_m(1, 16'h0004, 32'h11223344, 4'hF, 1);
      push_m(0, 16'h0008, 32'h0, 4'h0, 1);
      push_r(0, 32'hFFFB0004, 0);
      push_r(1, 32'hFFF70008, 0);
    end
    for (int i = 0; i < 2; i++)
      fork
        do_req(0, 1, 16'h0004, 32'h11223344, 4'hF, -1);
        do_req(1, 0, 16'h0008, 32'h0, 4'h0, -1);
      join
    push_m(0, 16'h0010, 32'h0, 4'h0, 1);
    push_r(0, 32'hDEADBEEF, 0);
    do_req(0, 0, 16'h0010, 32'h0, 4'h0, 2);
    mem_delay = 5;
    push_m(0, 16'h0020, 32'h0, 4'h0, 6);
    push_r(0, 32'hFFDF0020, 0);
    do_req(0, 0, 16'h0020, 32'h0, 4'h0, 7);
    mem_delay = 0;
    mem_dead = 1;
    push_m(0, 16'h0030, 32'h0, 4'h0, 8);
    push_r(1, 32'h0, 1);
    do_req(1, 0, 16'h0030, 32'h0, 4'h0, 9);
    mem_dead = 0;
    push_m(0, 16'h0040, 32'h0, 4'h0, 1);
    push_r(0, 32'hFFBF0040, 0);
    do_req(0, 0, 16'h0040, 32'h0, 4'h0, 2);
    // asynchronous abort, then a stray mem_ready in IDLE
    mem_dead = 1;
    rdy0 = n_rdy;
    push_m(0, 16'h0050, 32'h0, 4'h0, 2);
    req0_wr = 0; req0_addr = 16'h0050; req0_wdata = '0; req0_strb = '0; req0_en = 1;
    @(posedge aclk); #1;
    chk("areset_pre_en", 64'(mem_en), 64'(1));
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1; req0_en = 0;
    #1 chk("areset_async", 64'({mem_en, mem_wr, mem_addr, mem_wdata, mem_strb}), 64'(0));
    @(posedge aclk); #1;
    areset = 0;
    @(negedge aclk);
    mem_rdata = 32'hBADBAD00; mem_ready = 1;
    repeat (4) @(posedge aclk); #1;
    chk("areset_no_ready", 64'(n_rdy), 64'(rdy0));
    chk("areset_idle_en", 64'(mem_en), 64'(0));
    // synchronous abort takes effect only at the edge
    push_m(0, 16'h0050, 32'h0, 4'h0, 3);
    req0_en = 1;
    @(posedge aclk); #1;
    chk("srst_pre_en", 64'(mem_en), 64'(1));
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    srst = 1; req0_en = 0;
    #1 chk("srst_not_async", 64'(mem_en), 64'(1));
    @(posedge aclk); #1;
    chk("srst_edge", 64'({mem_en, mem_wr, mem_addr, mem_wdata, mem_strb}), 64'(0));
    srst = 0;
    @(negedge aclk);
    mem_rdata = 32'hBADBAD01; mem_ready = 1;
    repeat (4) @(posedge aclk); #1;
    chk("srst_no_ready", 64'(n_rdy), 64'(rdy0));
    mem_dead = 0;
    // en held through RESP and into IDLE yields exactly two transactions
    for (int i = 0; i < 2; i++) begin
      push_m(0, 16'h0060, 32'h0, 4'h0, 1);
      push_r(0, 32'hFF9F0060, 0);
    end
    do_req(0, 0, 16'h0060, 32'h0, 4'h0, 2);
    do_req(0, 0, 16'h0060, 32'h0, 4'h0, 2);
    repeat (6) @(posedge aclk); #1;
    chk("mem_queue_empty", 64'(mq.size()), 64'(0));
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/friscv_mem_arbiter.md
# friscv_mem_arbiter

Two-requester arbiter sharing the single data-memory port (mem_en/mem_wr/mem_addr/mem_wdata/mem_strb/mem_rdata/mem_ready) of the RV32I core.
- Requester 0 is the control/fetch unit; requester 1 is the ALU load/store path.
- Grants are round-robin, one transaction at a time.
- Request fields are registered onto the memory bus; the response is returned to the granted requester only.
- A watchdog terminates transactions the memory never acknowledges.

## Interface
- ADDRW, 16, address width
- XLEN, 32, data width; strobe width XLEN/8
- TIMEOUT, 256, max cycles waiting for mem_ready; must be >= 2
- aclk  in  1  clock, rising edge
- areset  in  1  asynchronous active-high reset
- srst  in  1  synchronous active-high clear; same effect as areset, applied at the clock edge
- req0_en  in  1  request valid; held with all fields stable until req0_ready
- req0_wr  in  1  1 = write, 0 = read
- req0_addr  in  ADDRW  address
- req0_wdata  in  XLEN  write data
- req0_strb  in  XLEN/8  byte enables
- req0_rdata  out  XLEN  read data; valid while req0_ready=1
- req0_ready  out  1  one-cycle completion pulse
- req0_err  out  1  timeout flag; valid while req0_ready=1
- req1_en, req1_wr, req1_addr, req1_wdata, req1_strb, req1_rdata, req1_ready, req1_err: same as the req0_* set, for requester 1
- mem_en  out  1  memory request; held until mem_ready
- mem_wr  out  1
- mem_addr  out  ADDRW
- mem_wdata  out  XLEN
- mem_strb  out  XLEN/8
- mem_rdata  in  XLEN  sampled when mem_ready=1
- mem_ready  in  1  memory completion

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - No reqN_en asserted: stay in IDLE.
  - Exactly one asserted: grant that requester.
  - Both asserted: grant the requester not granted last (`last` register).
  - On a grant: latch wr/addr/wdata/strb into the mem_* registers; set mem_en=1; update `last`; clear the watchdog; go to REQ.
- REQ:
  - mem_en and all mem_* fields stay stable.
  - mem_ready=1: capture mem_rdata into the response register; err=0; go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 with no mem_ready: response data=0, err=1, go to RESP. mem_en is dropped on that same edge.
- RESP:
  - mem_en=0.
  - reqG_ready=1 for exactly one cycle, with reqG_rdata and reqG_err valid (G = granted requester).
  - Then go to IDLE.
- Outputs of the non-granted requester are held at 0.
- On writes, reqG_rdata equals whatever mem_rdata was when mem_ready was sampled; requesters ignore it.
- A requester drops or changes its request on the cycle after it sees ready. Because the arbiter is in RESP that cycle, a still-asserted en is never double-granted.
- A reqN_en that deasserts before its grant is simply not served; this is not an error.
- areset/srst mid-transaction:
  - Abort immediately (areset) or at the clock edge (srst).
  - All outputs go to 0; no ready pulse is generated for the aborted request.
  - A late mem_ready in IDLE is ignored.
- mem_ready in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `last`=1, so requester 0 wins the first tie.
  - Watchdog=0.
  - mem_en, mem_wr, mem_addr, mem_wdata, mem_strb = 0.
  - All reqN_ready, reqN_rdata, reqN_err = 0.
- Cycle numbering:
  - Request sampled in IDLE at edge k; mem_en=1 from k to k+1.
  - mem_ready high in cycle k+1+d (d>=0 wait cycles).
  - reqG_ready high in cycle k+2+d; IDLE from k+3+d.
- Minimum round trip is 3 cycles per transaction. With both requesters saturating, grants alternate 0,1,0,1.
- Timeout: with no mem_ready, mem_en stays high for exactly TIMEOUT cycles; ready+err are asserted in the following cycle.
- mem_rdata is never combinationally passed through; every output is a register.

## Test plan
- Single read from requester 0:
  - Stimulus: addr=0x0010; memory answers mem_rdata=0xDEADBEEF with d=0.
  - Expect: mem_en high 1 cycle with mem_addr=0x0010, mem_wr=0; req0_ready pulse 1 cycle later with rdata=0xDEADBEEF, err=0.
  - Requester 1 outputs stay 0 throughout.
- Simultaneous requests after reset:
  - Stimulus: req0 write addr=0x0004 wdata=0x11223344 strb=0xF; req1 read addr=0x0008; both held.
  - Expect: req0 served first. req1's mem_en asserts in the first IDLE cycle after req0_ready.
  - Repeat both requests: grant order is 0,1,0,1.
- Wait states:
  - Stimulus: memory delays mem_ready by d=5.
  - Expect: mem_en and all fields stable for 6 cycles; ready pulse in cycle k+7.
- Timeout:
  - Stimulus: TIMEOUT=8; memory never responds to a req1 read.
  - Expect: mem_en high exactly 8 cycles, then req1_ready=1, req1_err=1, req1_rdata=0, then IDLE.
  - A subsequent req0 request is served normally.
- Reset during REQ:
  - Stimulus: assert areset while mem_en=1; memory raises mem_ready after reset release.
  - Expect: mem_en=0 asynchronously; no reqN_ready pulse; the stray mem_ready is ignored.
  - Stimulus: repeat with srst.
  - Expect: same result, at the next clock edge.
- Held en after ready:
  - Stimulus: req0 keeps en high through its RESP cycle and through one further IDLE cycle.
  - Expect: exactly two transactions, never a duplicate grant within RESP.
